uart_rx: RTL and testbench

Serial receiver paired with the `Tx` block: it samples the asynchronous `rx` line, recovers 8N1 frames at 9600 baud from a 50 MHz clock and presents each byte with a one-cycle strobe. Bit order and byte indexing match `Tx` exactly, so a `Tx` → `uart_rx` loopback returns `dataByte` unchanged. It sits between the board RX pin and the command/consumer logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 15 +
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Used by both the transmitter and uart_rx so baud timing stays consistent.
package uart_pkg;

    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned BAUD         = 9600;
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned DATA_W       = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte signals of uart_rx.
// The master side is the receiver; the slave side is the line driver and byte consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic              rx;
    logic [0:DATA_W-1] dataByte;
    logic              rxDone;
    logic              frameErr;
    logic              busy;

    modport master (input rx, output dataByte, output rxDone, output frameErr, output busy);
    modport slave  (output rx, input dataByte, input rxDone, input frameErr, input busy);

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// RESET_VAL sets the value both flops take during reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized line. Each byte is presented
// with a one-cycle rxDone strobe, and a bad stop bit raises a one-cycle frameErr instead.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_if.master       rx_bus
);
    import uart_pkg::*;

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_idx;
    logic [0:DATA_W-1] r_shift;
    logic [0:DATA_W-1] r_data;
    logic              r_done;
    logic              r_ferr;
    logic              r_busy;
    logic              w_rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (rx_bus.rx),
        .o_q     (w_rx_s)
    );

    // The counter matches the last count value so each sample lands exactly HALF_BIT/CLKS_PER_BIT edges on
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt  <= '0;
                    r_idx  <= '0;
                    r_busy <= 1'b0;
                    if (!w_rx_s) begin
                        r_state <= RX_START;
                        r_busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= RX_DATA;
                        end else begin
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_done  <= 1'b1;
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= RX_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_WAIT_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= RX_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.dataByte = r_data;
    assign rx_bus.rxDone   = r_done;
    assign rx_bus.frameErr = r_ferr;
    assign rx_bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are generated per bit with chosen lengths; a mid-bit sampling
// model over cycle positions predicts each received byte or framing error.
module tb_uart_rx;

    localparam int unsigned CPB  = 64;
    localparam int unsigned HALF = CPB / 2;

    logic clk = 1'b0;
    logic reset;

    uart_rx_if u_if();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HALF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx_bus (u_if.master)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned model_hold = 0;

    int unsigned obs_ev[$];
    int unsigned obs_cyc[$];
    int unsigned exp_ev[$];
    logic        prev_pulse = 1'b0;

    int unsigned nom[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Event word: bit 8 = framing error, bits 7:0 = dataByte seen with the pulse
    always @(negedge clk) begin
        if (u_if.rxDone || u_if.frameErr) begin
            check("pulse_excl", {31'd0, u_if.rxDone & u_if.frameErr}, 32'd0);
            check("pulse_consec", {31'd0, prev_pulse}, 32'd0);
            obs_ev.push_back((u_if.frameErr ? 32'h100 : 32'h0) | 32'(u_if.dataByte));
            obs_cyc.push_back(cyc);
        end
        prev_pulse <= u_if.rxDone | u_if.frameErr;
    end

    task automatic send_frame(input logic [7:0] v, input bit stop_lvl,
                              input int unsigned len[10], input int unsigned gap);
        bit          lvl[10];
        bit          smp[10];
        int unsigned bnd[11];
        int unsigned s;
        int unsigned rcv;
        lvl[0] = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i+1] = v[7-i];
        lvl[9] = stop_lvl;
        bnd[0] = 0;
        for (int j = 0; j < 10; j++) bnd[j+1] = bnd[j] + len[j];
        for (int k = 0; k < 10; k++) begin
            s = HALF + k * CPB;
            smp[k] = 1'b1;
            for (int j = 0; j < 10; j++)
                if (s >= bnd[j] && s < bnd[j+1]) smp[k] = lvl[j];
        end
        if (!smp[0]) begin
            rcv = 0;
            for (int i = 1; i <= 8; i++) rcv = (rcv << 1) | 32'(smp[i]);
            if (smp[9]) begin
                exp_ev.push_back(rcv);
                model_hold = rcv;
            end else begin
                exp_ev.push_back(32'h100 | model_hold);
            end
        end
        for (int j = 0; j < 10; j++) begin
            u_if.rx = lvl[j];
            repeat (len[j]) @(negedge clk);
        end
        u_if.rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++)
            check(tag, obs_ev[i], exp_ev[i]);
        obs_ev.delete();
        obs_cyc.delete();
        exp_ev.delete();
    endtask

    initial begin
        int unsigned c0;
        int unsigned len[10];
        logic [7:0]  pv;

        for (int j = 0; j < 10; j++) nom[j] = CPB;
        u_if.rx = 1'b1;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(u_if.dataByte), 32'd0);
        check("rst_done", {31'd0, u_if.rxDone}, 32'd0);
        check("rst_ferr", {31'd0, u_if.frameErr}, 32'd0);
        check("rst_busy", {31'd0, u_if.busy}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        c0 = cyc;
        send_frame(8'h35, 1'b1, nom, 2 * CPB);
        if (obs_cyc.size() > 0) check("latency_35", obs_cyc[0] - c0, 3 + HALF + 9 * CPB);
        else check("latency_35_seen", 32'd0, 32'd1);
        drain("byte_35");

        u_if.rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_hi", {31'd0, u_if.busy}, 32'd1);
        u_if.rx = 1'b1;
        repeat (HALF + 8) @(negedge clk);
        check("glitch_busy_lo", {31'd0, u_if.busy}, 32'd0);
        drain("glitch");

        send_frame(8'hFF, 1'b0, nom, 0);
        u_if.rx = 1'b0;
        repeat (1000) @(negedge clk);
        check("break_busy", {31'd0, u_if.busy}, 32'd1);
        u_if.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("break_idle", {31'd0, u_if.busy}, 32'd0);
        send_frame(8'h5A, 1'b1, nom, 2 * CPB);
        drain("frame_err");

        send_frame(8'h00, 1'b1, nom, 0);
        send_frame(8'hFF, 1'b1, nom, 0);
        send_frame(8'hA5, 1'b1, nom, 3 * CPB);
        drain("b2b");

        for (int j = 0; j < 10; j++) len[j] = CPB + 2;
        send_frame(8'hC3, 1'b1, len, 3 * CPB);
        for (int j = 0; j < 10; j++) len[j] = CPB - 2;
        send_frame(8'hC3, 1'b1, len, 3 * CPB);
        for (int j = 0; j < 10; j++) len[j] = CPB + 6;
        send_frame(8'hC3, 1'b1, len, 4 * CPB);
        for (int j = 0; j < 10; j++) len[j] = CPB - 6;
        send_frame(8'h3C, 1'b1, len, 4 * CPB);
        drain("drift");
        check("drift_idle", {31'd0, u_if.busy}, 32'd0);

        for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < 10; j++) len[j] = CPB - 2 + $urandom_range(0, 4);
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), len,
                       $urandom_range(2 * CPB, 4 * CPB));
        end
        drain("random");

        pv = 8'h3C;
        u_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = pv[7-i];
            repeat (CPB) @(negedge clk);
        end
        u_if.rx = pv[3];
        repeat (HALF) @(negedge clk);
        reset   = 1'b0;
        u_if.rx = 1'b1;
        @(negedge clk);
        check("midrst_data", 32'(u_if.dataByte), 32'd0);
        check("midrst_done", {31'd0, u_if.rxDone}, 32'd0);
        check("midrst_ferr", {31'd0, u_if.frameErr}, 32'd0);
        check("midrst_busy", {31'd0, u_if.busy}, 32'd0);
        reset      = 1'b1;
        model_hold = 0;
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'h81, 1'b1, nom, 2 * CPB);
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
